// File: rtl/sw_pkg.sv
// sw_pkg: shared encodings for the stopwatch run-control sequencer.
//   sw_state_e        : FSM state encoding (also exported on the debug port)
//   DSEL_*            : display source mux codes
//   dsel_of()         : display source selected by a given state
package sw_pkg;

    typedef enum logic [2:0] {
        SW_IDLE = 3'd0,
        SW_RUN  = 3'd1,
        SW_LAP  = 3'd2,
        SW_STOP = 3'd3
    } sw_state_e;

    localparam logic [1:0] DSEL_LIVE = 2'b00;
    localparam logic [1:0] DSEL_LAP  = 2'b01;
    localparam logic [1:0] DSEL_MSG  = 2'b10;

    function automatic logic [1:0] dsel_of(sw_state_e s);
        case (s)
            SW_LAP:  dsel_of = DSEL_LAP;
            SW_RUN,
            SW_STOP: dsel_of = DSEL_LIVE;
            default: dsel_of = DSEL_MSG;
        endcase
    endfunction

endpackage

// File: rtl/sw_btn_cond.sv
// sw_btn_cond: conditions one raw push button into a single-cycle press.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : 100 Hz pulse used to time the release hold-off
//   btn        : raw asynchronous button, active high
//   press      : one-cycle pulse on each accepted press
module sw_btn_cond #(
    parameter int SYNC_STAGES = 4,
    parameter int DEB_TICKS   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam logic [2:0] HOLD_LOAD = 3'(DEB_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             hold_q;
    logic                   held_q;
    logic                   s;
    logic                   held;

    assign s     = sync_q[SYNC_STAGES-1];
    // The counter keeps the button "held" for DEB_TICKS ticks after release,
    // so bounces inside that window just reload it and never re-trigger.
    assign held  = (hold_q != 3'd0);
    assign press = held & ~held_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hold_q <= 3'd0;
            held_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            if (s)
                hold_q <= HOLD_LOAD;
            else if (tick && held)
                hold_q <= hold_q - 3'd1;
            held_q <= held;
        end
    end

endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl: run/lap/stop/idle sequencer for the mm:ss.cc stopwatch.
//   clk, rst_n   : clock, synchronous active-low reset
//   tick         : 100 Hz pulse from the prescaler
//   bt_ss, bt_lr : raw start/stop and lap/reset buttons
//   at_max       : counter chain holds 59:59.99
//   count_en     : advance counter chain (combinational)
//   cnt_clr      : clear counter chain (registered pulse)
//   lap_load     : capture live time into lap register (registered pulse)
//   disp_sel     : display source (00 live, 01 lap, 10 idle message)
//   running      : RUN or LAP
//   state        : FSM state for debug
module sw_ctrl
    import sw_pkg::*;
#(
    parameter int SYNC_STAGES = 4,
    parameter int DEB_TICKS   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       bt_ss,
    input  logic       bt_lr,
    input  logic       at_max,
    output logic       count_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic [1:0] disp_sel,
    output logic       running,
    output logic [2:0] state
);

    localparam int NUM_BTN = 2;
    localparam int BTN_SS  = 0;
    localparam int BTN_LR  = 1;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    assign raw = {bt_lr, bt_ss};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        sw_btn_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_TICKS   (DEB_TICKS)
        ) u_cond (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (raw[b]),
            .press (press[b])
        );
    end

    sw_state_e  state_q, state_d;
    logic       lap_load_q, lap_load_d;
    logic       cnt_clr_q, cnt_clr_d;
    logic [1:0] disp_sel_q;
    logic       running_q;
    logic       counting;

    assign counting = (state_q == SW_RUN) | (state_q == SW_LAP);
    assign count_en = tick & counting & ~at_max;

    // Saturation beats both buttons; start/stop beats lap/reset.
    always_comb begin
        state_d    = state_q;
        lap_load_d = 1'b0;
        cnt_clr_d  = 1'b0;
        if (counting && tick && at_max) begin
            state_d = SW_STOP;
        end else if (press[BTN_SS]) begin
            case (state_q)
                SW_IDLE: state_d = SW_RUN;
                SW_RUN:  state_d = SW_STOP;
                SW_LAP:  state_d = SW_STOP;
                SW_STOP: state_d = SW_RUN;
                default: state_d = SW_IDLE;
            endcase
        end else if (press[BTN_LR]) begin
            case (state_q)
                SW_IDLE: cnt_clr_d = 1'b1;
                SW_RUN,
                SW_LAP: begin
                    state_d    = SW_LAP;
                    lap_load_d = 1'b1;
                end
                SW_STOP: begin
                    state_d   = SW_IDLE;
                    cnt_clr_d = 1'b1;
                end
                default: state_d = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SW_IDLE;
            lap_load_q <= 1'b0;
            cnt_clr_q  <= 1'b1;
            disp_sel_q <= DSEL_MSG;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lap_load_q <= lap_load_d;
            cnt_clr_q  <= cnt_clr_d;
            disp_sel_q <= dsel_of(state_d);
            running_q  <= (state_d == SW_RUN) | (state_d == SW_LAP);
        end
    end

    assign cnt_clr  = cnt_clr_q;
    assign lap_load = lap_load_q;
    assign disp_sel = disp_sel_q;
    assign running  = running_q;
    assign state    = state_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: directed + random stimulus against a behavioural model of the
// stopwatch run-control sequencer.
module tb_sw_ctrl;

    localparam int SYNC = 4;
    localparam int DEB  = 5;

    logic       clk = 1'b0;
    logic       rst_n, tick, bt_ss, bt_lr, at_max;
    logic       count_en, cnt_clr, lap_load, running;
    logic [1:0] disp_sel;
    logic [2:0] state;

    always #5 clk = ~clk;

    sw_ctrl #(.SYNC_STAGES(SYNC), .DEB_TICKS(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .bt_ss    (bt_ss),
        .bt_lr    (bt_lr),
        .at_max   (at_max),
        .count_en (count_en),
        .cnt_clr  (cnt_clr),
        .lap_load (lap_load),
        .disp_sel (disp_sel),
        .running  (running),
        .state    (state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Button path: a delay line of raw samples, then "ticks elapsed since the
    // synchronized level was last seen high"; the button counts as held until
    // DEB such ticks have passed.
    bit m_valid = 0;
    bit dly [2][SYNC];
    int since [2];
    bit hq [2];
    int m_state;   // 0 idle, 1 run, 2 lap, 3 stop
    bit m_clr, m_lap;

    function automatic int dsel_exp(int s);
        if (s == 2) return 1;
        if (s == 0) return 2;
        return 0;
    endfunction

    function automatic bit m_counting();
        return (m_state == 1) || (m_state == 2);
    endfunction

    task automatic model_edge();
        bit p [2];
        bit rawv [2];
        rawv[0] = bt_ss;
        rawv[1] = bt_lr;
        if (!rst_n) begin
            m_valid = 1;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < SYNC; i++) dly[b][i] = 0;
                since[b] = DEB;
                hq[b]    = 0;
            end
            m_state = 0; m_clr = 1; m_lap = 0;
        end else begin
            for (int b = 0; b < 2; b++) p[b] = (since[b] < DEB) && !hq[b];
            m_clr = 0; m_lap = 0;
            if (m_counting() && tick && at_max) m_state = 3;
            else if (p[0]) m_state = (m_state == 0 || m_state == 3) ? 1 : 3;
            else if (p[1]) begin
                if (m_state == 0) m_clr = 1;
                else if (m_state == 3) begin m_state = 0; m_clr = 1; end
                else begin m_state = 2; m_lap = 1; end
            end
            for (int b = 0; b < 2; b++) begin
                hq[b] = (since[b] < DEB);
                if (dly[b][SYNC-1]) since[b] = 0;
                else if (tick && since[b] < DEB) since[b]++;
                for (int i = SYNC-1; i > 0; i--) dly[b][i] = dly[b][i-1];
                dly[b][0] = rawv[b];
            end
        end
    endtask

    // One clock: drive inputs, check combinational enable, clock the model,
    // then check the registered outputs on the falling edge.
    task automatic cyc(input bit r, input bit tk, input bit ss, input bit lr, input bit am);
        rst_n = r; tick = tk; bt_ss = ss; bt_lr = lr; at_max = am;
        #1;
        if (m_valid) chk("count_en", count_en, int'(tk && m_counting() && !am));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("state",    state,    m_state);
        chk("disp_sel", disp_sel, dsel_exp(m_state));
        chk("running",  running,  int'(m_counting()));
        chk("lap_load", lap_load, int'(m_lap));
        chk("cnt_clr",  cnt_clr,  int'(m_clr));
    endtask

    // Hold a button for two clocks, then release long enough to clear the
    // hold-off window (ticks on alternate cycles).
    task automatic press(input bit ss, input bit lr);
        repeat (2) cyc(1, 0, ss, lr, 0);
        for (int i = 0; i < 30; i++) cyc(1, bit'(i % 2), 0, 0, 0);
    endtask

    int lap_cnt;

    initial begin
        rst_n = 0; tick = 0; bt_ss = 0; bt_lr = 0; at_max = 0;
        @(negedge clk);

        // reset for 3 cycles
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("rst_state", state, 0);
        chk("rst_dsel", disp_sel, 2);
        chk("rst_clr", cnt_clr, 1);
        cyc(1, 0, 0, 0, 0);
        chk("clr_one_cycle", cnt_clr, 0);

        // start: first sample at cycle 1, RUN visible after the 6th edge
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, i <= 2, 0, 0);
            if (i == 5) chk("start_lat_before", state, 0);
            if (i == 6) chk("start_lat_at", state, 1);
        end
        for (int i = 0; i < 30; i++) cyc(1, bit'(i % 3 == 0), 0, 0, 0);

        // lap, lap again
        lap_cnt = 0;
        repeat (2) cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++) begin
            cyc(1, bit'(i % 2), 0, 0, 0);
            lap_cnt += int'(lap_load);
        end
        chk("lap1_pulses", lap_cnt, 1);
        chk("lap1_dsel", disp_sel, 1);
        press(0, 1);
        chk("lap2_state", state, 2);

        // stop, resume, stop, clear
        press(1, 0);
        chk("stop_state", state, 3);
        for (int i = 0; i < 20; i++) cyc(1, bit'(i % 2), 0, 0, 0);
        press(1, 0);
        chk("resume_state", state, 1);
        press(1, 0);
        press(0, 1);
        chk("clear_state", state, 0);
        chk("clear_dsel", disp_sel, 2);

        // bounce: 1-0-1 with a short gap gives a single press
        repeat (2) cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, bit'(i % 2), 0, 0, 0);
        repeat (2) cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, bit'(i % 2), 0, 0, 0);
        chk("bounce_one_press", state, 1);
        press(1, 0);
        chk("second_press", state, 3);

        // saturation
        press(1, 0);
        repeat (3) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        chk("sat_stop", state, 3);

        // both buttons from RUN: start/stop wins
        press(1, 0);
        press(1, 1);
        chk("prio_stop", state, 3);

        // reset mid-lap with a button held
        press(1, 0);
        press(0, 1);
        repeat (3) cyc(1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("midrst_state", state, 0);
        chk("midrst_clr", cnt_clr, 1);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, bit'(i % 2), 0, 0, 0);
        chk("midrst_no_press", state, 0);

        // random phase
        begin
            bit ss = 0, lr = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) ss = ~ss;
                if ($urandom_range(15) == 0) lr = ~lr;
                cyc(($urandom_range(999) != 0), ($urandom_range(2) == 0),
                    ss, lr, ($urandom_range(19) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_ctrl.md
# sw_ctrl

Run-control sequencer for the 6-digit stopwatch (mm:ss.cc). It conditions the two user buttons (start/stop, lap/reset) and runs the run/lap/stop/idle state machine. Its outputs drive the BCD counter chain (count enable, clear), the lap capture register and the display source mux. It sits between `ui_in` and the counter/7-segment datapath, fed by the shared 100 Hz tick prescaler.

## Interface
- `SYNC_STAGES`, 4: synchronizer flops per raw button.
- `DEB_TICKS`, 5: hold-off in 100 Hz ticks after a button is seen released.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low. One clock; all flops reset on a `clk` edge with `rst_n`=0.
- `tick`  in  1  one-cycle 100 Hz pulse from the prescaler.
- `bt_ss`  in  1  raw start/stop button, active high, asynchronous.
- `bt_lr`  in  1  raw lap/reset button, active high, asynchronous.
- `at_max`  in  1  counter chain currently holds 59:59.99.
- `count_en`  out  1  advance counter chain this cycle.
- `cnt_clr`  out  1  synchronous clear of counter chain.
- `lap_load`  out  1  capture live time into lap register.
- `disp_sel`  out  2  display source: 00 live, 01 lap, 10 idle message, 11 unused.
- `running`  out  1  high in RUN or LAP.
- `state`  out  3  FSM state, for debug.

## Operation
- **Per-button conditioning:**
  - The raw input passes through a `SYNC_STAGES` shift register, giving `s`.
  - A 3-bit hold counter loads `DEB_TICKS` while `s`=1. While `s`=0 and the counter is nonzero, it decrements on `tick`.
  - `held` = (counter != 0). `press` = `held & ~held_q`.
  - Bounces shorter than `DEB_TICKS` ticks produce no second `press`.
- **Priority:** if both presses occur in the same cycle, start/stop wins and lap/reset is dropped.
- **States (encoding):** IDLE=0, RUN=1, LAP=2, STOP=3.
  - IDLE: `disp_sel`=10. ss → RUN. lr → IDLE, with a `cnt_clr` pulse.
  - RUN: `disp_sel`=00. ss → STOP. lr → LAP, with a `lap_load` pulse.
  - LAP: `disp_sel`=01, counting continues. lr → LAP, with a `lap_load` pulse (new lap). ss → STOP.
  - STOP: `disp_sel`=00. ss → RUN (resume, no clear). lr → IDLE, with a `cnt_clr` pulse.
- **Count enable:** `count_en` = `tick & (state==RUN | state==LAP) & ~at_max`.
- **Saturation:** `tick & at_max` in RUN or LAP forces → STOP. The counter holds at 59:59.99 and never wraps to 00:00.00.
- **Reset values:** state=IDLE, `cnt_clr`=1, `lap_load`=0, `disp_sel`=10, `running`=0, `count_en`=0. All synchronizer and hold counters reset to 0.

## Timing
- `count_en` is combinational from `tick`/state/`at_max`, with zero latency. All other outputs are registered.
- **Raw press to state:**
  - The button is first sampled high at edge k.
  - `s` goes high after edge k+`SYNC_STAGES`−1.
  - `held` goes high after edge k+`SYNC_STAGES`.
  - `press` is high for that one cycle.
  - state, `disp_sel`, `running`, `lap_load` and `cnt_clr` update at edge k+`SYNC_STAGES`+1.
- **Pulses:** `lap_load` and `cnt_clr` are exactly one cycle wide per accepted press. `cnt_clr` is also high for the first cycle after reset release.
- **Press coinciding with `tick`:** the FSM is evaluated on the current state, so the tick is counted or not per the current state.
- **Press coinciding with `tick & at_max`:** a start/stop press wins → STOP, which is the same result. A lap/reset press is dropped.
- **Reset mid-operation:** `rst_n`=0 at any edge overrides everything. Pending presses and hold counts are discarded.

## Structure
- Shared package `sw_pkg` holds:
  - the state encoding constants `SW_IDLE`, `SW_RUN`, `SW_LAP`, `SW_STOP`;
  - the `disp_sel` codes `DSEL_LIVE`, `DSEL_LAP`, `DSEL_MSG`.
- One sub-module `sw_btn_cond` (synchronizer, hold counter, edge detect; parameters `SYNC_STAGES`, `DEB_TICKS`), instantiated twice.
- FSM and output registers live in `sw_ctrl`.

## Test plan
- **Reset then start:**
  - Hold `rst_n`=0 for 3 cycles, then release. Expect IDLE, `disp_sel`=10 and one `cnt_clr` cycle.
  - Pulse `bt_ss` for 1 µs. Expect state=RUN exactly 6 edges after the first sample, and `count_en` on every subsequent `tick`.
- **Lap:**
  - In RUN, press `bt_lr`. Expect one `lap_load` cycle, `disp_sel`=01, `count_en` continuing on each tick.
  - Press `bt_lr` again. Expect a second `lap_load`, still LAP.
- **Stop/resume/clear:**
  - RUN, then ss → STOP; verify `count_en`=0 for 10 ticks.
  - ss again → RUN with no `cnt_clr`.
  - ss → STOP, then lr → IDLE with one `cnt_clr` and `disp_sel`=10.
- **Debounce:**
  - Bounce `bt_ss` 1-0-1 with gaps of 2 ticks, i.e. less than `DEB_TICKS`=5. Expect exactly one `press`.
  - Release for 6 ticks, then press. Expect a second accepted press.
- **Saturation and priority:**
  - Hold `at_max`=1 in RUN. Next `tick`: expect `count_en`=0 and state=STOP.
  - Assert `bt_ss` and `bt_lr` together from RUN. Expect STOP and no `lap_load`.
- **Reset mid-run:** drop `rst_n` in LAP while a button is held. Expect all outputs at reset values the next cycle, and no spurious `press` after release.
